cmsdk_uart_cmd_decoder: RTL and testbench



---
 rtl/cmsdk_uart_cmd_pkg.sv | 24 ++
 rtl/cmsdk_uart_rx_core.sv | 95 +++++++++
 rtl/cmsdk_uart_cmd_decoder.sv | 85 ++++++++
 tb/tb_cmsdk_uart_cmd_decoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cmsdk_uart_cmd_pkg.sv
// Shared command constants and state encodings for the UART stdout
// receiver and its escape-command decoder.
package cmsdk_uart_cmd_pkg;

    localparam logic [7:0] CMD_ESC     = 8'h1B;
    localparam logic [7:0] CMD_DBG_EN  = 8'h11;
    localparam logic [7:0] CMD_DBG_DIS = 8'h12;
    localparam logic [7:0] CMD_AUX     = 8'h13;
    localparam logic [7:0] CMD_SIMEND  = 8'h04;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_ESC,
        ST_AUX
    } cmd_state_t;

endpackage

// File: rtl/cmsdk_uart_rx_core.sv
// 8N1 UART deserialiser: 2-FF synchroniser, RX FSM and bit timer.
// rx_valid/rx_ferr are strobes in the stop-sample cycle; rx_data holds the byte.
module cmsdk_uart_rx_core
    import cmsdk_uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rxs;
    logic             rxs_q;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             stop_bad;
    logic             stop_tick;

    assign stop_tick = (state == RX_STOP) && !stop_bad && (cnt == BIT_LAST);
    assign rx_data   = shreg;
    assign rx_valid  = stop_tick && rxs;
    assign rx_ferr   = stop_tick && !rxs;

    // Synchroniser and edge history reset low, so a line already low at
    // reset release never looks like a 1->0 start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b0;
            rxs      <= 1'b0;
            rxs_q    <= 1'b0;
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            stop_bad <= 1'b0;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
            rxs_q   <= rxs;
            case (state)
                RX_IDLE: begin
                    if (rxs_q && !rxs) begin
                        state <= RX_START;
                        cnt   <= CNT_W'(1);  // edge cycle itself is count 0
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (stop_bad) begin
                        if (rxs) begin
                            stop_bad <= 1'b0;
                            state    <= RX_IDLE;
                        end
                    end else if (cnt == BIT_LAST) begin
                        if (rxs) state <= RX_IDLE;
                        else     stop_bad <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cmsdk_uart_cmd_decoder.sv
// Testbench-side stdout UART receiver: delivers ordinary characters and
// turns ESC-prefixed sequences into sticky control outputs.
module cmsdk_uart_cmd_decoder
    import cmsdk_uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       RXD,
    output logic [7:0] BYTE_DATA,
    output logic       BYTE_VALID,
    output logic       FRAME_ERR,
    output logic       DEBUG_TESTER_ENABLE,
    output logic [7:0] AUXCTRL,
    output logic       SIMULATIONEND
);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    cmd_state_t cmd_state;

    cmsdk_uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_core (
        .clk      (CLK),
        .rst_n    (RESETn),
        .rxd      (RXD),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cmd_state           <= ST_NORMAL;
            BYTE_DATA           <= 8'h00;
            BYTE_VALID          <= 1'b0;
            FRAME_ERR           <= 1'b0;
            DEBUG_TESTER_ENABLE <= 1'b0;
            AUXCTRL             <= 8'h00;
            SIMULATIONEND       <= 1'b0;
        end else begin
            BYTE_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            if (rx_ferr) begin
                // A corrupted frame abandons any half-parsed command.
                FRAME_ERR <= 1'b1;
                cmd_state <= ST_NORMAL;
            end else if (rx_valid) begin
                case (cmd_state)
                    ST_NORMAL: begin
                        if (rx_data == CMD_ESC) begin
                            cmd_state <= ST_ESC;
                        end else begin
                            BYTE_DATA  <= rx_data;
                            BYTE_VALID <= 1'b1;
                        end
                    end
                    ST_ESC: begin
                        cmd_state <= ST_NORMAL;
                        case (rx_data)
                            CMD_DBG_EN:  DEBUG_TESTER_ENABLE <= 1'b1;
                            CMD_DBG_DIS: DEBUG_TESTER_ENABLE <= 1'b0;
                            CMD_SIMEND:  SIMULATIONEND       <= 1'b1;
                            CMD_AUX:     cmd_state           <= ST_AUX;
                            CMD_ESC:     cmd_state           <= ST_ESC;
                            default: begin
                                BYTE_DATA  <= rx_data;
                                BYTE_VALID <= 1'b1;
                            end
                        endcase
                    end
                    ST_AUX: begin
                        AUXCTRL   <= rx_data;
                        cmd_state <= ST_NORMAL;
                    end
                    default: cmd_state <= ST_NORMAL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmsdk_uart_cmd_decoder.sv
// Directed bench for cmsdk_uart_cmd_decoder: a frame table plus hand-written
// timing, glitch, back-to-back and mid-frame reset sequences.
module tb_cmsdk_uart_cmd_decoder;

    localparam int CPB = 16;
    // RXD drive cycle to BYTE_VALID cycle: 2 sync + CPB/2-1 + 9*CPB + 1
    localparam int LAT = 2 + CPB / 2 - 1 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;
    logic       dbg_en;
    logic [7:0] auxctrl;
    logic       simend;

    cmsdk_uart_cmd_decoder #(.CLKS_PER_BIT(CPB)) dut (
        .CLK                 (clk),
        .RESETn              (rst_n),
        .RXD                 (rxd),
        .BYTE_DATA           (byte_data),
        .BYTE_VALID          (byte_valid),
        .FRAME_ERR           (frame_err),
        .DEBUG_TESTER_ENABLE (dbg_en),
        .AUXCTRL             (auxctrl),
        .SIMULATIONEND       (simend)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int last_valid_cyc = -1;
    int dbg_rise_cyc = -1;
    logic dbg_q = 1'b0;
    int fall_cyc = 0;
    int total = 0;
    int bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid) begin
            n_valid <= n_valid + 1;
            last_valid_cyc <= cyc;
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (dbg_en && !dbg_q) dbg_rise_cyc <= cyc;
        dbg_q <= dbg_en;
    end

    typedef struct {
        logic [7:0] din;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_nv;
        int         exp_nf;
        logic       exp_dbg;
        logic [7:0] exp_aux;
        logic       exp_se;
    } vec_t;

    vec_t vecs[29];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the stop bit plus idle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int idle);
        rxd = 1'b0;
        fall_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, 32'(byte_data), 32'h00);
        chk({tag, "_valid"}, 32'(byte_valid), 32'h0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'h0);
        chk({tag, "_dbg"}, 32'(dbg_en), 32'h0);
        chk({tag, "_aux"}, 32'(auxctrl), 32'h00);
        chk({tag, "_simend"}, 32'(simend), 32'h0);
    endtask

    initial begin
        int nv0, nf0;
        logic [7:0] rb;

        vecs[0]  = '{8'h41, 1'b1, 8'h41, 1, 0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{8'h1B, 1'b1, 8'h41, 0, 0, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{8'h11, 1'b1, 8'h41, 0, 0, 1'b1, 8'h00, 1'b0};
        vecs[3]  = '{8'h1B, 1'b1, 8'h41, 0, 0, 1'b1, 8'h00, 1'b0};
        vecs[4]  = '{8'h12, 1'b1, 8'h41, 0, 0, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{8'h1B, 1'b1, 8'h41, 0, 0, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{8'h13, 1'b1, 8'h41, 0, 0, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{8'hA5, 1'b1, 8'h41, 0, 0, 1'b0, 8'hA5, 1'b0};
        vecs[8]  = '{8'h1B, 1'b1, 8'h41, 0, 0, 1'b0, 8'hA5, 1'b0};
        vecs[9]  = '{8'h58, 1'b1, 8'h58, 1, 0, 1'b0, 8'hA5, 1'b0};
        vecs[10] = '{8'h3C, 1'b0, 8'h58, 0, 1, 1'b0, 8'hA5, 1'b0};
        vecs[11] = '{8'h1B, 1'b1, 8'h58, 0, 0, 1'b0, 8'hA5, 1'b0};
        vecs[12] = '{8'h1B, 1'b1, 8'h58, 0, 0, 1'b0, 8'hA5, 1'b0};
        vecs[13] = '{8'h11, 1'b1, 8'h58, 0, 0, 1'b1, 8'hA5, 1'b0};
        vecs[14] = '{8'h1B, 1'b1, 8'h58, 0, 0, 1'b1, 8'hA5, 1'b0};
        vecs[15] = '{8'h13, 1'b1, 8'h58, 0, 0, 1'b1, 8'hA5, 1'b0};
        vecs[16] = '{8'h1B, 1'b1, 8'h58, 0, 0, 1'b1, 8'h1B, 1'b0};
        vecs[17] = '{8'h1B, 1'b1, 8'h58, 0, 0, 1'b1, 8'h1B, 1'b0};
        vecs[18] = '{8'h13, 1'b1, 8'h58, 0, 0, 1'b1, 8'h1B, 1'b0};
        vecs[19] = '{8'h77, 1'b0, 8'h58, 0, 1, 1'b1, 8'h1B, 1'b0};
        vecs[20] = '{8'h22, 1'b1, 8'h22, 1, 0, 1'b1, 8'h1B, 1'b0};
        vecs[21] = '{8'h1B, 1'b1, 8'h22, 0, 0, 1'b1, 8'h1B, 1'b0};
        vecs[22] = '{8'h04, 1'b1, 8'h22, 0, 0, 1'b1, 8'h1B, 1'b1};
        vecs[23] = '{8'h0A, 1'b1, 8'h0A, 1, 0, 1'b1, 8'h1B, 1'b1};
        vecs[24] = '{8'h1B, 1'b1, 8'h0A, 0, 0, 1'b1, 8'h1B, 1'b1};
        vecs[25] = '{8'h12, 1'b1, 8'h0A, 0, 0, 1'b0, 8'h1B, 1'b1};
        vecs[26] = '{8'h1B, 1'b1, 8'h0A, 0, 0, 1'b0, 8'h1B, 1'b1};
        vecs[27] = '{8'h3C, 1'b0, 8'h0A, 0, 1, 1'b0, 8'h1B, 1'b1};
        vecs[28] = '{8'h11, 1'b1, 8'h11, 1, 0, 1'b0, 8'h1B, 1'b1};

        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        foreach (vecs[k]) begin
            nv0 = n_valid;
            nf0 = n_ferr;
            send_frame(vecs[k].din, vecs[k].stop, 30);
            chk($sformatf("v%0d_nvalid", k), 32'(n_valid - nv0), 32'(vecs[k].exp_nv));
            chk($sformatf("v%0d_nferr", k), 32'(n_ferr - nf0), 32'(vecs[k].exp_nf));
            chk($sformatf("v%0d_data", k), 32'(byte_data), 32'(vecs[k].exp_data));
            chk($sformatf("v%0d_dbg", k), 32'(dbg_en), 32'(vecs[k].exp_dbg));
            chk($sformatf("v%0d_aux", k), 32'(auxctrl), 32'(vecs[k].exp_aux));
            chk($sformatf("v%0d_simend", k), 32'(simend), 32'(vecs[k].exp_se));
        end

        // BYTE_VALID lands exactly LAT cycles after RXD falls
        send_frame(8'h41, 1'b1, 30);
        chk("valid_cycle", 32'(last_valid_cyc - fall_cyc), 32'(LAT));
        chk("valid_cycle_data", 32'(byte_data), 32'h41);

        // control update lands on the same byte-complete cycle
        send_frame(8'h1B, 1'b1, 30);
        send_frame(8'h11, 1'b1, 30);
        chk("dbg_rise_cycle", 32'(dbg_rise_cyc - fall_cyc), 32'(LAT));

        // glitches of 5 and CPB/2-1 low cycles are ignored
        nv0 = n_valid;
        nf0 = n_ferr;
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        rxd = 1'b0;
        repeat (CPB / 2 - 1) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_nvalid", 32'(n_valid - nv0), 32'h0);
        chk("glitch_nferr", 32'(n_ferr - nf0), 32'h0);

        // back-to-back frames, zero idle between stop and next start
        nv0 = n_valid;
        send_frame(8'h31, 1'b1, 0);
        send_frame(8'h32, 1'b1, 30);
        chk("b2b_nvalid", 32'(n_valid - nv0), 32'h2);
        chk("b2b_data", 32'(byte_data), 32'h32);

        // reset during bit 3; line held low across release
        rb = 8'h5A;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = rb[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = rb[3];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("midreset");
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        chk_reset_outputs("postrel");
        nv0 = n_valid;
        nf0 = n_ferr;
        send_frame(8'h55, 1'b1, 30);
        chk("after_reset_nvalid", 32'(n_valid - nv0), 32'h1);
        chk("after_reset_nferr", 32'(n_ferr - nf0), 32'h0);
        chk("after_reset_data", 32'(byte_data), 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
